// File: rtl/btn_pkg.sv
// Shared types for the button event scheduler: hold-FSM states and the
// event record carried by the output register.
package btn_pkg;

  localparam int N_BTN_DEFAULT = 4;

  // Widest event id ever needed (N_BTN tops out at 8).
  localparam int EVT_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HOLD,
    REPEAT
  } hold_st_e;

  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    logic                rpt;
  } btn_evt_t;

endpackage

// File: rtl/btn_hold_ctr.sv
// One button: rising-edge detect, hold-to-repeat FSM and its down-counter.
// evt_o is a registered single-cycle pulse; rpt_o qualifies it
// (0 = initial press, 1 = auto-repeat).
module btn_hold_ctr
  import btn_pkg::*;
#(
  parameter int HOLD_CYC   = 50000000,
  parameter int REPEAT_CYC = 10000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic evt_o,
  output logic rpt_o
);

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RPT_LD  = CW'(REPEAT_CYC - 1);

  hold_st_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          evt_q, evt_d;
  logic          rpt_q, rpt_d;

  // State, counter, previous level and event pulse registers.
  // NOTE: non-blocking (<=) in clocked blocks so every register updates from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      evt_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= btn_i;
      evt_q   <= evt_d;
      rpt_q   <= rpt_d;
    end
  end

  // Next-state logic; a release always wins over a same-cycle expiry.
  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_i && !prev_q) begin
          evt_d   = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = WAIT_HOLD;
        end
      end
      WAIT_HOLD: begin
        if (!btn_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          evt_d   = 1'b1;
          rpt_d   = 1'b1;
          cnt_d   = RPT_LD;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          evt_d = 1'b1;
          rpt_d = 1'b1;
          cnt_d = RPT_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign evt_o = evt_q;
  assign rpt_o = rpt_q;

endmodule

// File: rtl/btn_evt_sched.sv
// Button event scheduler: per-button hold counters feed one pending slot
// each; a round-robin arbiter drains the slots into a valid/ready output
// register, one event per cycle when the consumer keeps up.
module btn_evt_sched
  import btn_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEFAULT,
  parameter int HOLD_CYC   = 50000000,
  parameter int REPEAT_CYC = 10000000,
  localparam int IDW       = $clog2(N_BTN)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             evt_ready_i,
  output logic             evt_valid_o,
  output logic [IDW-1:0]   evt_id_o,
  output logic             evt_rpt_o,
  output logic             drop_o,
  output logic [N_BTN-1:0] pend_o
);

  logic [N_BTN-1:0] ev, ev_rpt;

  for (genvar k = 0; k < N_BTN; k++) begin : g_hold
    btn_hold_ctr #(
      .HOLD_CYC  (HOLD_CYC),
      .REPEAT_CYC(REPEAT_CYC)
    ) u_hold (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .btn_i (btn_i[k]),
      .evt_o (ev[k]),
      .rpt_o (ev_rpt[k])
    );
  end

  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] rpt_q, rpt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  btn_evt_t         out_q, out_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  int               idx;
  logic [N_BTN-1:0] grant;
  logic             load;

  // Pending slots, arbiter pointer and output register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q  <= '0;
      rpt_q   <= '0;
      ptr_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      rpt_q   <= rpt_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Round-robin search: first pending bit at or above ptr, wrapping to 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_BTN) idx = idx - N_BTN;
      cand = IDW'(idx);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Output load, grant and slot update; a new event beats a same-cycle grant.
  always_comb begin
    pend_d  = pend_q;
    rpt_d   = rpt_q;
    ptr_d   = ptr_q;
    out_d   = out_q;
    valid_d = valid_q;
    drop_d  = 1'b0;
    grant   = '0;
    load    = !valid_q || evt_ready_i;

    if (load) begin
      if (found) begin
        valid_d    = 1'b1;
        out_d.id   = EVT_ID_W'(win);
        out_d.rpt  = rpt_q[win];
        grant[win] = 1'b1;
        ptr_d      = (win == IDW'(N_BTN - 1)) ? '0 : win + 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    for (int k = 0; k < N_BTN; k++) begin
      if (ev[k]) begin
        if (pend_q[k] && !grant[k]) begin
          drop_d = 1'b1;
        end else begin
          pend_d[k] = 1'b1;
          rpt_d[k]  = ev_rpt[k];
        end
      end else if (grant[k]) begin
        pend_d[k] = 1'b0;
      end
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_id_o    = IDW'(out_q.id);
  assign evt_rpt_o   = out_q.rpt;
  assign drop_o      = drop_q;
  assign pend_o      = pend_q;

endmodule

// File: tb/tb_btn_evt_sched.sv
// Bench for btn_evt_sched: directed scenarios plus randomized button/ready
// traffic, scored against a behavioural model based on hold age.
module tb_btn_evt_sched;

  localparam int N = 4;
  localparam int H = 8;
  localparam int R = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn;
  logic         ready;
  logic         evt_valid_o;
  logic [1:0]   evt_id_o;
  logic         evt_rpt_o;
  logic         drop_o;
  logic [N-1:0] pend_o;

  btn_evt_sched #(
    .N_BTN     (N),
    .HOLD_CYC  (H),
    .REPEAT_CYC(R)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .btn_i      (btn),
    .evt_ready_i(ready),
    .evt_valid_o(evt_valid_o),
    .evt_id_o   (evt_id_o),
    .evt_rpt_o  (evt_rpt_o),
    .drop_o     (drop_o),
    .pend_o     (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  int drop_cnt = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int   stamp;
    int   id;
    logic rpt;
  } acc_t;

  acc_t accq[$];
  int   dropq[$];

  bit           m_hold[N];
  int           m_age[N];
  logic [N-1:0] m_prev     = '0;
  logic [N-1:0] m_pipe_ev  = '0;
  logic [N-1:0] m_pipe_rpt = '0;
  logic [N-1:0] m_pend     = '0;
  logic [N-1:0] m_rpt      = '0;
  int           m_ptr      = 0;
  logic         m_valid    = 1'b0;
  int           m_id       = 0;
  logic         m_orpt     = 1'b0;

  logic [N-1:0] c_pend  = '0;
  logic         c_valid = 1'b0;
  int           c_id    = 0;
  logic         c_orpt  = 1'b0;

  always @(posedge clk) cyc++;

  // Predicts the effect of the next clock edge from the inputs it will sample.
  task automatic model_step();
    int           win;
    bit           drop;
    logic [N-1:0] nev, nrpt;
    c_pend  = m_pend;
    c_valid = m_valid;
    c_id    = m_id;
    c_orpt  = m_orpt;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_hold[k] = 1'b0;
        m_age[k]  = 0;
      end
      m_prev = '0; m_pipe_ev = '0; m_pipe_rpt = '0;
      m_pend = '0; m_rpt = '0; m_ptr = 0;
      m_valid = 1'b0; m_id = 0; m_orpt = 1'b0;
    end else begin
      if (m_valid && ready) accq.push_back('{cyc, m_id, m_orpt});
      if (!m_valid || ready) begin
        win = -1;
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (win < 0 && m_pend[j]) win = j;
        end
        if (win >= 0) begin
          m_valid     = 1'b1;
          m_id        = win;
          m_orpt      = m_rpt[win];
          m_pend[win] = 1'b0;
          m_ptr       = (win + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
      drop = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_pipe_ev[k]) begin
          if (m_pend[k]) drop = 1'b1;
          else begin
            m_pend[k] = 1'b1;
            m_rpt[k]  = m_pipe_rpt[k];
          end
        end
      end
      if (drop) dropq.push_back(cyc + 1);
      nev = '0;
      nrpt = '0;
      for (int k = 0; k < N; k++) begin
        if (btn[k]) begin
          if (!m_prev[k]) begin
            m_hold[k] = 1'b1;
            m_age[k]  = 0;
            nev[k]    = 1'b1;
          end else if (m_hold[k]) begin
            m_age[k]++;
            if (m_age[k] >= H && (m_age[k] - H) % R == 0) begin
              nev[k]  = 1'b1;
              nrpt[k] = 1'b1;
            end
          end
        end else begin
          m_hold[k] = 1'b0;
        end
        m_prev[k] = btn[k];
      end
      m_pipe_ev  = nev;
      m_pipe_rpt = nrpt;
    end
  endtask

  always begin
    @(posedge clk);
    #3;
    model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(evt_valid_o), 32'(c_valid));
      check("pend", 32'(pend_o), 32'(c_pend));
      check("id", 32'(evt_id_o), 32'(c_id));
      check("rpt", 32'(evt_rpt_o), 32'(c_orpt));

      while (dropq.size() > 0 && dropq[0] < cyc) begin
        fail_now("drop_missing", 0, dropq[0]);
        void'(dropq.pop_front());
      end
      if (drop_o) begin
        drop_cnt++;
        if (dropq.size() == 0) fail_now("drop_unexpected", cyc, -1);
        else check("drop_cycle", 32'(cyc), 32'(dropq.pop_front()));
      end

      while (accq.size() > 0 && accq[0].stamp < cyc) begin
        fail_now("accept_missing", 0, accq[0].stamp);
        void'(accq.pop_front());
      end
      if (rst_n && evt_valid_o && ready) begin
        acc_t e;
        acc_cnt++;
        if (accq.size() == 0) begin
          fail_now("accept_unexpected", cyc, -1);
        end else begin
          e = accq.pop_front();
          check("acc_cycle", 32'(cyc), 32'(e.stamp));
          check("acc_id", 32'(evt_id_o), 32'(e.id));
          check("acc_rpt", 32'(evt_rpt_o), 32'(e.rpt));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [N-1:0] b, input logic r, input logic rs);
    @(posedge clk);
    #2;
    btn   = b;
    ready = r;
    rst_n = rs;
  endtask

  task automatic step(input logic [N-1:0] b, input logic r);
    drive(b, r, 1'b1);
  endtask

  int a0, d0;
  logic [N-1:0] rb;

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    ready = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) drive('0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_valid", 32'(evt_valid_o), 0);
    check("rst_id", 32'(evt_id_o), 0);
    check("rst_rpt", 32'(evt_rpt_o), 0);
    check("rst_drop", 32'(drop_o), 0);
    check("rst_pend", 32'(pend_o), 0);

    // Single tap.
    a0 = acc_cnt;
    repeat (3) step(4'b0001, 1'b1);
    repeat (6) step(4'b0000, 1'b1);
    check("tap_events", 32'(acc_cnt - a0), 1);

    // Hold: press plus repeats at +8, +12, +16.
    a0 = acc_cnt;
    repeat (20) step(4'b0100, 1'b1);
    repeat (8) step(4'b0000, 1'b1);
    check("hold_events", 32'(acc_cnt - a0), 4);

    // Two simultaneous presses of all buttons.
    a0 = acc_cnt;
    repeat (2) begin
      repeat (3) step(4'b1111, 1'b1);
      repeat (6) step(4'b0000, 1'b1);
    end
    check("simul_events", 32'(acc_cnt - a0), 8);

    // Backpressure.
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    repeat (4) step(4'b0000, 1'b0);
    @(negedge clk);
    check("bp_valid", 32'(evt_valid_o), 1);
    check("bp_id", 32'(evt_id_o), 0);
    check("bp_pend", 32'(pend_o), 32'h2);
    a0 = acc_cnt;
    repeat (2) step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    @(negedge clk);
    check("bp_drained", 32'(evt_valid_o), 0);
    check("bp_events", 32'(acc_cnt - a0), 2);

    // Overflow of button 3's slot.
    d0 = drop_cnt;
    repeat (30) step(4'b1000, 1'b0);
    repeat (4) step(4'b0000, 1'b0);
    @(negedge clk);
    check("ovf_pend", 32'(pend_o), 32'h8);
    check("ovf_drops", 32'(drop_cnt - d0), 5);
    check("ovf_id", 32'(evt_id_o), 3);
    repeat (4) step(4'b0000, 1'b1);

    // Reset while button 1 is repeating.
    repeat (12) step(4'b0010, 1'b1);
    drive(4'b0010, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b1);
    @(negedge clk);
    check("mid_rst_valid", 32'(evt_valid_o), 0);
    check("mid_rst_pend", 32'(pend_o), 0);
    check("mid_rst_id", 32'(evt_id_o), 0);
    a0 = acc_cnt;
    repeat (3) step(4'b0010, 1'b1);
    @(negedge clk);
    check("post_rst_valid", 32'(evt_valid_o), 1);
    check("post_rst_id", 32'(evt_id_o), 1);
    check("post_rst_rpt", 32'(evt_rpt_o), 0);
    repeat (3) step(4'b0010, 1'b1);
    repeat (4) step(4'b0000, 1'b1);
    check("post_rst_events", 32'(acc_cnt - a0), 1);

    // Randomized traffic with occasional resets.
    rb = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 9) == 0) rb[k] = ~rb[k];
      drive(rb, $urandom_range(0, 3) != 0, $urandom_range(0, 399) != 0);
    end
    repeat (20) step(4'b0000, 1'b1);
    @(negedge clk);
    check("accq_empty", 32'(accq.size()), 0);
    check("dropq_empty", 32'(dropq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
